// File: rtl/fp21_div.sv
// Restoring FP21 divider (q = a / b), one quotient bit per cycle; out_valid rises 18 cycles after accept.
// Single operation in flight: in_ready only in IDLE, result held until out_ready. Option: FP21_DIV_ZERO_FLAG_EN.
module fp21_div #(
  parameter int FRAC_W = 13,
  parameter int EXP_W  = 9,
  parameter int QBITS  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign_a,
  input  logic              sign_b,
  input  logic [EXP_W-1:0]  exp_a,
  input  logic [EXP_W-1:0]  exp_b,
  input  logic [FRAC_W-1:0] frac_a,
  input  logic [FRAC_W-1:0] frac_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign_q,
  output logic [EXP_W-1:0]  exp_q,
  output logic [FRAC_W-1:0] frac_q
`ifdef FP21_DIV_ZERO_FLAG_EN
  ,
  output logic              div_by_zero
`endif
);

  localparam int CNT_W = $clog2(QBITS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(QBITS - 1);

  typedef enum logic [2:0] {IDLE, DIV, NORM, ROUND, DONE} state_t;

  state_t state, state_nxt;

  logic              sign_r;
  logic [EXP_W-1:0]  exp_a_r, exp_b_r, e_r;
  logic [FRAC_W-1:0] fb_r, m_r;
  logic [FRAC_W:0]   rem;
  logic [QBITS-1:0]  quo;
  logic [CNT_W-1:0]  cnt;
  logic              g_r, r_r, s_r;
  logic [FRAC_W+1:0] trial;
  logic              ge;
  logic              up;
`ifdef FP21_DIV_ZERO_FLAG_EN
  logic              dz_r;
`endif

  // One extra bit on top of rem so the borrow shows up as a sign bit.
  assign trial = {1'b0, rem} - {2'b00, fb_r};
  assign ge    = ~trial[FRAC_W+1];
  assign up    = g_r & (r_r | s_r | m_r[0]);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = DIV;
      DIV:     if (cnt == LAST) state_nxt = NORM;
      NORM:    state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_r  <= 1'b0;
      exp_a_r <= '0;
      exp_b_r <= '0;
      e_r     <= '0;
      fb_r    <= '0;
      m_r     <= '0;
      rem     <= '0;
      quo     <= '0;
      cnt     <= '0;
      g_r     <= 1'b0;
      r_r     <= 1'b0;
      s_r     <= 1'b0;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      frac_q  <= '0;
`ifdef FP21_DIV_ZERO_FLAG_EN
      dz_r        <= 1'b0;
      div_by_zero <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_r  <= sign_a ^ sign_b;
            exp_a_r <= exp_a;
            exp_b_r <= exp_b;
            fb_r    <= frac_b;
            rem     <= {1'b0, frac_a};
            quo     <= '0;
            cnt     <= '0;
`ifdef FP21_DIV_ZERO_FLAG_EN
            dz_r    <= ~frac_b[FRAC_W-1];
`endif
          end
        end
        DIV: begin
          quo <= {quo[QBITS-2:0], ge};
          rem <= ge ? {trial[FRAC_W-1:0], 1'b0} : {rem[FRAC_W-1:0], 1'b0};
          cnt <= cnt + CNT_W'(1);
        end
        NORM: begin
          // Quotient lies in [0.5, 2): at most one position of left shift needed.
          if (quo[QBITS-1]) begin
            m_r <= quo[QBITS-1 -: FRAC_W];
            g_r <= quo[2];
            r_r <= quo[1];
            s_r <= quo[0] | (|rem);
            e_r <= exp_a_r - exp_b_r;
          end else begin
            m_r <= quo[QBITS-2 -: FRAC_W];
            g_r <= quo[1];
            r_r <= quo[0];
            s_r <= |rem;
            e_r <= exp_a_r - exp_b_r - {{(EXP_W-1){1'b0}}, 1'b1};
          end
        end
        ROUND: begin
          sign_q <= sign_r;
          exp_q  <= e_r;
          frac_q <= m_r + {{(FRAC_W-1){1'b0}}, up};
`ifdef FP21_DIV_ZERO_FLAG_EN
          div_by_zero <= dz_r;
          if (dz_r) begin
            exp_q  <= '1;
            frac_q <= '1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
